// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - shared snooping-bus controller with round-robin arbiter and 8x4 main memory
//
// Purpose: captures per-CPU miss/invalidate messages, grants one at a time in
// round-robin order, broadcasts a snoop, takes an optional owner write-back,
// accesses main memory and returns a one-cycle reply to the requester.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   bus_out_cpu  in   NUM_CPU x 10: [9] readMiss [8] writeMiss [7] invalidate [6:4] addr [3:0] data
//   wb_valid     in   NUM_CPU: CPU supplies modified data for the snooped address
//   wb_data      in   NUM_CPU x 4 write-back data
//   bus_in_cpu   out  NUM_CPU x 11: [10] snoop [9] ack [8] kill [7] read [6:4] addr [3:0] data
//   busy         out  high whenever a transaction is in flight

module bus_controller #(
   parameter int         NUM_CPU  = 3,
   parameter logic [3:0] MEM_INIT = 4'h0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_CPU*10-1:0]  bus_out_cpu,
   input  logic [NUM_CPU-1:0]     wb_valid,
   input  logic [NUM_CPU*4-1:0]   wb_data,
   output logic [NUM_CPU*11-1:0]  bus_in_cpu,
   output logic                   busy
);

   localparam int CW = $clog2(NUM_CPU);

   typedef logic [CW-1:0] cpu_t;
   typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_WB, S_REPLY} state_t;
   typedef enum logic [1:0] {T_NONE, T_RM, T_WM, T_INV} req_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_CPU-1:0]    r_pending;
   req_t                  r_req_type [NUM_CPU];
   logic [2:0]            r_req_addr [NUM_CPU];
   cpu_t                  r_ptr;
   cpu_t                  r_cur_cpu;
   req_t                  r_cur_type;
   logic [2:0]            r_cur_addr;
   logic [3:0]            r_mem [8];
   logic [NUM_CPU*11-1:0] r_bus_in;

   logic                  w_grant_found;
   cpu_t                  w_grant_idx;
   cpu_t                  w_ptr_nxt;
   logic [CW:0]           w_sum;
   logic [NUM_CPU*11-1:0] w_snoop;
   logic [NUM_CPU*11-1:0] w_reply;
   logic                  w_wb_hit;
   logic [3:0]            w_wb_nib;
   logic [3:0]            w_reply_data;
   logic [NUM_CPU*4-1:0]  w_unused_data;

   // The data nibble of a request message carries nothing for this block.
   for (genvar g = 0; g < NUM_CPU; g++) begin : g_unused
      assign w_unused_data[4*g +: 4] = bus_out_cpu[10*g +: 4];
   end

   // Round-robin search: walk from the farthest candidate back toward the
   // pointer so the candidate closest to the pointer is written last and wins.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_sum         = '0;
      for (int k = NUM_CPU - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (CW+1)'(k);
         if (w_sum >= (CW+1)'(NUM_CPU)) begin
            w_sum = w_sum - (CW+1)'(NUM_CPU);
         end
         if (r_pending[w_sum[CW-1:0]]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_sum[CW-1:0];
         end
      end
   end

   assign w_ptr_nxt = (w_grant_idx == cpu_t'(NUM_CPU - 1)) ? '0 : w_grant_idx + cpu_t'(1);

   // Snoop broadcast for the CPU about to be granted; the requester sees nothing.
   always_comb begin
      w_snoop = '0;
      for (int j = 0; j < NUM_CPU; j++) begin
         if (cpu_t'(j) != w_grant_idx) begin
            w_snoop[11*j +: 11] = {1'b1, 1'b0,
                                   (r_req_type[w_grant_idx] == T_WM) || (r_req_type[w_grant_idx] == T_INV),
                                   (r_req_type[w_grant_idx] == T_RM),
                                   r_req_addr[w_grant_idx], 4'h0};
         end
      end
   end

   // Owner write-back: the requester's own wb_valid is masked; lowest index wins.
   always_comb begin
      w_wb_hit = 1'b0;
      w_wb_nib = '0;
      for (int j = NUM_CPU - 1; j >= 0; j--) begin
         if (wb_valid[j] && (cpu_t'(j) != r_cur_cpu)) begin
            w_wb_hit = 1'b1;
            w_wb_nib = wb_data[4*j +: 4];
         end
      end
   end

   assign w_reply_data = w_wb_hit ? w_wb_nib :
                         (r_cur_type == T_INV) ? 4'h0 : r_mem[r_cur_addr];

   always_comb begin
      w_reply = '0;
      for (int j = 0; j < NUM_CPU; j++) begin
         if (cpu_t'(j) == r_cur_cpu) begin
            w_reply[11*j +: 11] = {1'b0, 1'b1, 2'b00, r_cur_addr, w_reply_data};
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant_found) w_state_nxt = S_SNOOP;
         S_SNOOP: w_state_nxt = S_WB;
         S_WB:    w_state_nxt = S_REPLY;
         S_REPLY: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pending  <= '0;
         r_ptr      <= '0;
         r_cur_cpu  <= '0;
         r_cur_type <= T_NONE;
         r_cur_addr <= '0;
         r_bus_in   <= '0;
         for (int i = 0; i < NUM_CPU; i++) begin
            r_req_type[i] <= T_NONE;
            r_req_addr[i] <= '0;
         end
         for (int a = 0; a < 8; a++) begin
            r_mem[a] <= MEM_INIT;
         end
      end else begin
         // Capture only into empty slots; a grant below only clears a slot that
         // was already full, so the two never touch the same bit on one edge.
         for (int i = 0; i < NUM_CPU; i++) begin
            if (!r_pending[i] && (|bus_out_cpu[10*i+7 +: 3])) begin
               r_pending[i]  <= 1'b1;
               r_req_addr[i] <= bus_out_cpu[10*i+4 +: 3];
               if (bus_out_cpu[10*i+7])      r_req_type[i] <= T_INV;
               else if (bus_out_cpu[10*i+8]) r_req_type[i] <= T_WM;
               else                          r_req_type[i] <= T_RM;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_grant_found) begin
                  r_pending[w_grant_idx] <= 1'b0;
                  r_cur_cpu              <= w_grant_idx;
                  r_cur_type             <= r_req_type[w_grant_idx];
                  r_cur_addr             <= r_req_addr[w_grant_idx];
                  r_ptr                  <= w_ptr_nxt;
                  r_bus_in               <= w_snoop;
               end
            end
            S_SNOOP: r_bus_in <= '0;
            S_WB: begin
               if (w_wb_hit) r_mem[r_cur_addr] <= w_wb_nib;
               r_bus_in <= w_reply;
            end
            S_REPLY: r_bus_in <= '0;
            default: r_bus_in <= '0;
         endcase
      end
   end

   assign bus_in_cpu = r_bus_in;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - scoreboard bench for bus_controller with directed vectors

module tb_bus_controller;

   logic        clock;
   logic        reset;
   logic [29:0] bus_out_cpu;
   logic [2:0]  wb_valid;
   logic [11:0] wb_data;
   logic [32:0] bus_in_cpu;
   logic        busy;

   bus_controller #(.NUM_CPU(3), .MEM_INIT(4'h0)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus_out_cpu(bus_out_cpu),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .bus_in_cpu (bus_in_cpu),
      .busy       (busy)
   );

   typedef struct {
      int          cyc;
      logic [32:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [29:0] msg(int cpu, bit rm, bit wm, bit inv, logic [2:0] a);
      logic [29:0] v;
      v = '0;
      v[10*cpu +: 10] = {rm, wm, inv, a, 4'h5};
      return v;
   endfunction

   function automatic logic [32:0] snoop_vec(int req, bit kill, bit rd, logic [2:0] a);
      logic [32:0] v;
      v = '0;
      for (int j = 0; j < 3; j++)
         if (j != req) v[11*j +: 11] = {1'b1, 1'b0, kill, rd, a, 4'h0};
      return v;
   endfunction

   function automatic logic [32:0] ack_vec(int req, logic [2:0] a, logic [3:0] d);
      logic [32:0] v;
      v = '0;
      v[11*req +: 11] = {1'b0, 1'b1, 2'b00, a, d};
      return v;
   endfunction

   task automatic expect_txn(input string nm, input int req, input bit kill, input bit rd,
                             input logic [2:0] a, input logic [3:0] d, input int g);
      exp_t e;
      e.cyc = g;     e.val = snoop_vec(req, kill, rd, a); e.name = {nm, "_snoop"};
      q.push_back(e);
      e.cyc = g + 2; e.val = ack_vec(req, a, d);          e.name = {nm, "_ack"};
      q.push_back(e);
   endtask

   // Monitor: every non-zero bus cycle must match the next scoreboard entry.
   always @(negedge clock) begin
      if (!reset && bus_in_cpu != '0) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %0h at cycle %0d expected none", bus_in_cpu, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.name, "_value"}, 64'(bus_in_cpu), 64'(e.val));
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            check({e.name, "_busy"}, 64'(busy), 64'd1);
         end
      end
   end

   task automatic pulse(input logic [29:0] v, output int n);
      @(posedge clock); #1;
      bus_out_cpu = v;
      @(posedge clock); #1;
      n = cyc;
      bus_out_cpu = '0;
   endtask

   task automatic pulse_at(input int target, input logic [29:0] v);
      while (cyc < target - 1) begin @(posedge clock); #1; end
      bus_out_cpu = v;
      @(posedge clock); #1;
      bus_out_cpu = '0;
   endtask

   task automatic wb_at(input int target, input logic [2:0] vld, input logic [11:0] d);
      while (cyc < target - 1) begin @(posedge clock); #1; end
      wb_valid = vld;
      wb_data  = d;
      @(posedge clock); #1;
      wb_valid = '0;
      wb_data  = '0;
   endtask

   task automatic drain(input string nm);
      int i;
      i = 0;
      while (q.size() != 0 && i < 80) begin
         @(posedge clock);
         i++;
      end
      repeat (2) @(posedge clock);
      #1;
      check({nm, "_drained"}, 64'(q.size()), 64'd0);
      check({nm, "_idle_busy"}, 64'(busy), 64'd0);
      q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_bus_in", 64'(bus_in_cpu), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      reset       = 1'b1;
      bus_out_cpu = '0;
      wb_valid    = '0;
      wb_data     = '0;
      do_reset();

      // CPU0 readMiss addr 3 from fresh memory
      pulse(msg(0, 1, 0, 0, 3'd3), n);
      expect_txn("rm0_a3", 0, 0, 1, 3'd3, 4'h0, n + 1);
      drain("rm0_a3");

      // CPU1 readMiss addr 5, CPU2 supplies A
      pulse(msg(1, 1, 0, 0, 3'd5), n);
      expect_txn("rm1_a5_wb", 1, 0, 1, 3'd5, 4'hA, n + 1);
      wb_at(n + 3, 3'b100, 12'hA00);
      drain("rm1_a5_wb");

      // Memory now holds A at 5
      pulse(msg(0, 1, 0, 0, 3'd5), n);
      expect_txn("rm0_a5_mem", 0, 0, 1, 3'd5, 4'hA, n + 1);
      drain("rm0_a5_mem");

      // readMiss+invalidate -> invalidate: kill snoop, reply 0, memory untouched
      pulse(msg(1, 1, 0, 1, 3'd5), n);
      expect_txn("inv1_a5", 1, 1, 0, 3'd5, 4'h0, n + 1);
      drain("inv1_a5");

      pulse(msg(2, 1, 0, 0, 3'd5), n);
      expect_txn("rm2_a5_mem", 2, 0, 1, 3'd5, 4'hA, n + 1);
      drain("rm2_a5_mem");

      // Pointer is back at 0: simultaneous CPU0 invalidate and CPU2 writeMiss
      pulse(msg(0, 0, 0, 1, 3'd2) | msg(2, 0, 1, 0, 3'd6), n);
      expect_txn("inv0_a2", 0, 1, 0, 3'd2, 4'h0, n + 1);
      expect_txn("wm2_a6", 2, 1, 0, 3'd6, 4'h0, n + 5);
      drain("contention");

      // Fairness: all request, each re-requests right after its ack
      pulse(msg(0, 1, 0, 0, 3'd1) | msg(1, 0, 1, 0, 3'd2) | msg(2, 1, 1, 0, 3'd3), n);
      for (int k = 0; k < 6; k++) begin
         case (k % 3)
            0: expect_txn($sformatf("rr%0d_cpu0", k), 0, 0, 1, 3'd1, 4'h0, n + 1 + 4*k);
            1: expect_txn($sformatf("rr%0d_cpu1", k), 1, 1, 0, 3'd2, 4'h0, n + 1 + 4*k);
            default: expect_txn($sformatf("rr%0d_cpu2", k), 2, 1, 0, 3'd3, 4'h0, n + 1 + 4*k);
         endcase
      end
      pulse_at(n + 2, msg(2, 1, 0, 0, 3'd7));
      pulse_at(n + 4, msg(0, 1, 0, 0, 3'd1));
      pulse_at(n + 8, msg(1, 0, 1, 0, 3'd2));
      pulse_at(n + 12, msg(2, 1, 1, 0, 3'd3));
      drain("round_robin");

      // Write-back: requester masked, lowest remaining index (CPU1) wins
      pulse(msg(0, 1, 0, 0, 3'd4), n);
      expect_txn("rm0_a4_wb", 0, 0, 1, 3'd4, 4'h7, n + 1);
      wb_at(n + 3, 3'b111, 12'hE7F);
      drain("rm0_a4_wb");

      // Reset during SNOOP of a CPU1 request
      begin
         exp_t e;
         pulse(msg(1, 1, 0, 0, 3'd4), n);
         e.cyc = n + 1; e.val = snoop_vec(1, 0, 1, 3'd4); e.name = "rst_rm1_snoop";
         q.push_back(e);
         while (cyc < n + 1) begin @(posedge clock); #1; end
         @(negedge clock);
         #2;
         reset = 1'b1;
         #1;
         check("async_reset_bus_in", 64'(bus_in_cpu), 64'd0);
         check("async_reset_busy", 64'(busy), 64'd0);
         check("snoop_before_reset", 64'(q.size()), 64'd0);
         repeat (2) @(posedge clock);
         #1;
         reset = 1'b0;
         repeat (10) @(posedge clock);
         #1;
         check("no_ack_after_reset", 64'(bus_in_cpu), 64'd0);
         check("idle_after_reset", 64'(busy), 64'd0);
         q.delete();
      end

      // Memory back at MEM_INIT
      pulse(msg(0, 1, 0, 0, 3'd4), n);
      expect_txn("post_rst_rm0_a4", 0, 0, 1, 3'd4, 4'h0, n + 1);
      drain("post_rst_rm0_a4");

      // Requester's own write-back is ignored
      pulse(msg(2, 1, 0, 0, 3'd4), n);
      expect_txn("self_wb_rm2_a4", 2, 0, 1, 3'd4, 4'h0, n + 1);
      wb_at(n + 3, 3'b100, 12'hF00);
      drain("self_wb_rm2_a4");

      pulse(msg(1, 1, 0, 0, 3'd5), n);
      expect_txn("post_rst_rm1_a5", 1, 0, 1, 3'd5, 4'h0, n + 1);
      drain("post_rst_rm1_a5");

      pulse(msg(0, 1, 0, 0, 3'd4), n);
      expect_txn("no_self_wb_write", 0, 0, 1, 3'd4, 4'h0, n + 1);
      drain("no_self_wb_write");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
